copper_fetch: RTL and testbench

- Instruction fetch/prefetch stage between the two copper memory halves (even and odd) and the copper execute unit.
- Drives one shared read address to both halves and assembles each returned pair into a 32-bit instruction.
- Buffers up to two instructions and presents them on a valid/ready handshake.
- Handles frame restart and jumps by flushing the buffer and discarding any read in flight.

---
 rtl/copper_fetch.sv | 66 ++++++
 tb/tb_copper_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/copper_fetch.sv
// copper_fetch: copper instruction prefetch, pairs even/odd halves into a 2-deep FIFO with flush on restart/jump
module copper_fetch #(
    parameter int                AWIDTH       = 10,
    parameter logic [AWIDTH-1:0] RESTART_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic              jump_i,
    input  logic [AWIDTH-1:0] jump_addr_i,
    output logic [AWIDTH-1:0] rd_address_o,
    input  logic [15:0]       rd_data_even_i,
    input  logic [15:0]       rd_data_odd_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [AWIDTH-1:0] instr_pc_o,
    input  logic              instr_ready_i
);
    logic [AWIDTH-1:0] addr_q, addr_d, tag_q, tag_d, pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0]       ins0_q, ins0_d, ins1_q, ins1_d;
    logic [1:0]        count_q, count_d, left;
    logic [2:0]        occ;
    logic              inflight_q, inflight_d, pop, push, flush, issue;
    always_comb begin
        flush      = restart_i | jump_i;
        pop        = (count_q != 2'd0) & instr_ready_i;
        push       = inflight_q & ~flush;
        left       = count_q - {1'b0, pop};
        occ        = {1'b0, left} + {2'b0, inflight_q};
        issue      = en_i & ~flush & (occ < 3'd2);
        addr_d     = restart_i ? RESTART_ADDR : jump_i ? jump_addr_i : issue ? addr_q + AWIDTH'(1) : addr_q;
        inflight_d = issue;
        tag_d      = issue ? addr_q : tag_q;
        ins0_d     = (push && left == 2'd0) ? {rd_data_even_i, rd_data_odd_i} : pop ? ins1_q : ins0_q;
        pc0_d      = (push && left == 2'd0) ? tag_q : pop ? pc1_q : pc0_q;
        ins1_d     = (push && left == 2'd1) ? {rd_data_even_i, rd_data_odd_i} : ins1_q;
        pc1_d      = (push && left == 2'd1) ? tag_q : pc1_q;
        count_d    = flush ? 2'd0 : left + {1'b0, push};
    end
    always_ff @(posedge clk) begin
        if (reset_i) begin
            addr_q     <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            ins0_q     <= '0;
            ins1_q     <= '0;
            pc0_q      <= '0;
            pc1_q      <= '0;
            count_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            count_q    <= count_d;
        end
    end
    assign rd_address_o  = addr_q;
    assign instr_valid_o = count_q != 2'd0;
    assign instr_o       = ins0_q;
    assign instr_pc_o    = pc0_q;
endmodule

// File: tb/tb_copper_fetch.sv
// tb_copper_fetch: scoreboard bench for copper_fetch with a 1-cycle even/odd memory model
module tb_copper_fetch;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1, en_i = 1'b0, restart_i = 1'b0, jump_i = 1'b0, instr_ready_i = 1'b0;
    logic [9:0]  jump_addr_i = '0, rd_address_o, instr_pc_o;
    logic [15:0] rd_data_even_i = '0, rd_data_odd_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [9:0]  exp_q[$];
    int          checks = 0, failures = 0;

    copper_fetch #(.AWIDTH(10), .RESTART_ADDR(10'h000)) dut (
        .clk(clk), .reset_i(reset_i), .en_i(en_i), .restart_i(restart_i), .jump_i(jump_i),
        .jump_addr_i(jump_addr_i), .rd_address_o(rd_address_o), .rd_data_even_i(rd_data_even_i),
        .rd_data_odd_i(rd_data_odd_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_even_i <= 16'hE000 | {6'd0, rd_address_o};
        rd_data_odd_i  <= {6'd0, rd_address_o};
    end

    function automatic logic [31:0] word_of(input logic [9:0] p);
        return {16'hE000 | {6'd0, p}, {6'd0, p}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got pc %h expected none", instr_pc_o);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", {22'd0, instr_pc_o}, {22'd0, e});
                chk("sb_instr", instr_o, word_of(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [9:0] start, input int n);
        logic [9:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 10'd1;
        end
    endtask

    task automatic wait_for(input logic [9:0] pc);
        int k;
        k = 0;
        while (!(instr_valid_o && instr_pc_o == pc) && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) begin
            checks++;
            failures++;
            $display("FAIL wait_pc: got pc %h valid %b expected pc %h", instr_pc_o, instr_valid_o, pc);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_addr", {22'd0, rd_address_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", {22'd0, instr_pc_o}, 32'd0);
        reset_i = 1'b0;
        push_seq(10'h000, 8);
        en_i = 1'b1;
        instr_ready_i = 1'b1;
        wait_for(10'h002);
        instr_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_addr", {22'd0, rd_address_o}, 32'd4);
            chk("bp_instr", instr_o, 32'hE0020002);
            chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
        end
        instr_ready_i = 1'b1;
        wait_for(10'h005);
        jump_i = 1'b1;
        jump_addr_i = 10'h155;
        tick();
        jump_i = 1'b0;
        exp_q.delete();
        push_seq(10'h155, 8);
        chk("jmp_valid_n1", {31'd0, instr_valid_o}, 32'd0);
        chk("jmp_addr_n1", {22'd0, rd_address_o}, 32'h155);
        tick();
        chk("jmp_valid_n2", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("jmp_valid_n3", {31'd0, instr_valid_o}, 32'd1);
        chk("jmp_pc_n3", {22'd0, instr_pc_o}, 32'h155);
        chk("jmp_instr_n3", instr_o, 32'hE1550155);
        wait_for(10'h157);
        jump_i = 1'b1;
        jump_addr_i = 10'h3FE;
        tick();
        jump_i = 1'b0;
        exp_q.delete();
        push_seq(10'h3FE, 16);
        chk("wrap_addr", {22'd0, rd_address_o}, 32'h3FE);
        wait_for(10'h002);
        en_i = 1'b0;
        tick();
        chk("off_valid1", {31'd0, instr_valid_o}, 32'd1);
        chk("off_pc1", {22'd0, instr_pc_o}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("off_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("off_addr", {22'd0, rd_address_o}, 32'd4);
        end
        en_i = 1'b1;
        wait_for(10'h008);
        restart_i = 1'b1;
        jump_i = 1'b1;
        jump_addr_i = 10'h020;
        tick();
        restart_i = 1'b0;
        jump_i = 1'b0;
        exp_q.delete();
        push_seq(10'h000, 8);
        chk("rs_addr", {22'd0, rd_address_o}, 32'd0);
        chk("rs_valid", {31'd0, instr_valid_o}, 32'd0);
        wait_for(10'h000);
        wait_for(10'h003);
        reset_i = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_addr", {22'd0, rd_address_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mid_rst_instr", instr_o, 32'd0);
        chk("mid_rst_pc", {22'd0, instr_pc_o}, 32'd0);
        reset_i = 1'b0;
        en_i = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("post_rst_addr", {22'd0, rd_address_o}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
